// File: rtl/hist_eq_pkg.sv
// Shared constants, state encoding and bin decode for the histogram equalizer stages.
package hist_eq_pkg;

  localparam int          BINS         = 256;
  localparam logic [15:0] TAG          = 16'hAAAA;
  localparam int          CNT_W        = 20;
  localparam int          ADDR_W       = 16;
  localparam int          NUM_W        = 27;
  localparam int          TOTAL_PIXELS = 307200;

  typedef enum logic [2:0] {
    CDF_IDLE     = 3'd0,
    CDF_SCAN     = 3'd1,
    CDF_EVAL_RD  = 3'd2,
    CDF_EVAL_DIV = 3'd3,
    CDF_EVAL_WR  = 3'd4,
    CDF_DONE     = 3'd5
  } cdf_state_t;

  // Untagged scratchpad entries are treated as empty bins.
  function automatic logic [CNT_W-1:0] bin_count(input logic [35:0] entry);
    return (entry[35:20] == TAG) ? entry[CNT_W-1:0] : '0;
  endfunction

endpackage

// File: rtl/lut_divider.sv
// Restoring divider producing an 8-bit quotient, one bit per cycle, MSB first.
module lut_divider
  import hist_eq_pkg::*;
(
  input  logic             clock,
  input  logic             rst_n,
  input  logic             load,
  input  logic [NUM_W-1:0] num,
  input  logic [CNT_W-1:0] den,
  output logic [7:0]       q,
  output logic             busy
);

  logic [NUM_W-1:0] rem;
  logic [NUM_W-1:0] den_sh;
  logic [3:0]       steps;
  logic             den_zero;
  logic             take;

  assign take = !den_zero && (rem >= den_sh);

  // busy drops during the final step so the parent leaves its wait state in
  // lockstep with the last quotient bit landing.
  assign busy = load || (steps > 4'd1);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      den_sh   <= '0;
      steps    <= '0;
      den_zero <= 1'b0;
      q        <= '0;
    end else if (load) begin
      rem      <= num;
      den_sh   <= {den, 7'b0};
      steps    <= 4'd8;
      den_zero <= (den == '0);
      q        <= '0;
    end else if (steps != 4'd0) begin
      if (take) rem <= rem - den_sh;
      q      <= {q[6:0], take};
      den_sh <= den_sh >> 1;
      steps  <= steps - 4'd1;
    end
  end

endmodule

// File: rtl/cdf_lut_builder.sv
// Builds the equalization LUT from the tagged histogram in scratchpad m2.
// IDLE clear | SCAN total/cdf_min | EVAL_RD cdf+load | EVAL_DIV divide | EVAL_WR lut write | DONE hold
module cdf_lut_builder
  import hist_eq_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic              inputBaseOffset,
  output logic [ADDR_W-1:0] m2ReadAddr,
  input  logic [35:0]       m2ReadBus,
  output logic              lutWE,
  output logic [7:0]        lutWriteAddr,
  output logic [7:0]        lutWriteData,
  output logic              cdf_done
);

  cdf_state_t       state;
  logic [7:0]       bin;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] cdf_min;
  logic [CNT_W-1:0] cdf;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cdf_new;
  logic [CNT_W-1:0] diff;
  logic [NUM_W-1:0] num;
  logic [CNT_W-1:0] den;
  logic             div_load;
  logic [7:0]       div_q;
  logic             div_busy;

  assign m2ReadAddr = {inputBaseOffset, 7'b0, bin};
  assign count      = bin_count(m2ReadBus);
  assign cdf_new    = cdf + count;
  assign diff       = cdf_new - cdf_min;
  assign num        = (cdf_new >= cdf_min) ? {7'b0, diff} * 27'd255 : '0;
  assign den        = total - cdf_min;
  assign div_load   = (state == CDF_EVAL_RD);

  lut_divider u_div (
    .clock (clock),
    .rst_n (rst_n),
    .load  (div_load),
    .num   (num),
    .den   (den),
    .q     (div_q),
    .busy  (div_busy)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CDF_IDLE;
      bin          <= '0;
      total        <= '0;
      cdf_min      <= '0;
      cdf          <= '0;
      lutWE        <= 1'b0;
      lutWriteAddr <= '0;
      lutWriteData <= '0;
      cdf_done     <= 1'b0;
    end else if (!start || state == CDF_IDLE) begin
      // Dropping start abandons any partial LUT; the next run starts from scratch.
      state        <= start ? CDF_SCAN : CDF_IDLE;
      bin          <= '0;
      total        <= '0;
      cdf_min      <= '0;
      cdf          <= '0;
      lutWE        <= 1'b0;
      lutWriteAddr <= '0;
      lutWriteData <= '0;
      cdf_done     <= 1'b0;
    end else begin
      lutWE <= 1'b0;
      case (state)
        CDF_SCAN: begin
          total <= total + count;
          if (cdf_min == '0 && count != '0) cdf_min <= count;
          if (bin == 8'd255) begin
            state <= CDF_EVAL_RD;
            cdf   <= '0;
          end
          bin <= bin + 8'd1;
        end
        CDF_EVAL_RD: begin
          cdf   <= cdf_new;
          state <= CDF_EVAL_DIV;
        end
        CDF_EVAL_DIV: begin
          if (!div_busy) state <= CDF_EVAL_WR;
        end
        CDF_EVAL_WR: begin
          lutWE        <= 1'b1;
          lutWriteAddr <= bin;
          lutWriteData <= div_q;
          if (bin == 8'd255) begin
            state <= CDF_DONE;
          end else begin
            bin   <= bin + 8'd1;
            state <= CDF_EVAL_RD;
          end
        end
        CDF_DONE: begin
          cdf_done <= 1'b1;
        end
        default: state <= CDF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdf_lut_builder.sv
// Scoreboard bench for cdf_lut_builder: expected LUT writes are queued per run, a monitor checks them.
module tb_cdf_lut_builder;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        start;
  logic        inputBaseOffset;
  logic [15:0] m2ReadAddr;
  logic [35:0] m2ReadBus;
  logic        lutWE;
  logic [7:0]  lutWriteAddr;
  logic [7:0]  lutWriteData;
  logic        cdf_done;

  logic [35:0] mem [0:1][0:255];
  logic [15:0] exp_q [$];
  logic [15:0] exp_e;
  int          exp_lut [256];
  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  int          addr_bad = 0;
  int          edge_cnt = 0;

  cdf_lut_builder dut (
    .clock           (clock),
    .rst_n           (rst_n),
    .start           (start),
    .inputBaseOffset (inputBaseOffset),
    .m2ReadAddr      (m2ReadAddr),
    .m2ReadBus       (m2ReadBus),
    .lutWE           (lutWE),
    .lutWriteAddr    (lutWriteAddr),
    .lutWriteData    (lutWriteData),
    .cdf_done        (cdf_done)
  );

  assign m2ReadBus = mem[m2ReadAddr[15]][m2ReadAddr[7:0]];

  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Rising edges seen with start high since it was last asserted.
  initial begin
    forever begin
      @(posedge clock);
      edge_cnt = start ? edge_cnt + 1 : 0;
    end
  end

  // Monitor: every LUT write pops the next expected (addr, data) and checks its cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (rst_n && lutWE) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr %0d data %0d at edge %0d, expected no write",
                   lutWriteAddr, lutWriteData, edge_cnt);
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_addr", lutWriteAddr, exp_e[15:8]);
          check("wr_data", lutWriteData, exp_e[7:0]);
          check("wr_edge", edge_cnt, 267 + 10 * int'(exp_e[15:8]));
        end
      end
      if (rst_n && start && (m2ReadAddr[14:8] != 7'd0 || m2ReadAddr[15] !== inputBaseOffset))
        addr_bad++;
    end
  end

  task automatic push_lut(input int upto);
    for (int b = 0; b < upto; b++) exp_q.push_back({8'(b), 8'(exp_lut[b])});
  endtask

  task automatic fill_bank(input int bank, input logic [35:0] v);
    for (int b = 0; b < 256; b++) mem[bank][b] = v;
  endtask

  task automatic run_full(input string name);
    int done_edge;
    wr_cnt   = 0;
    addr_bad = 0;
    done_edge = -1;
    @(negedge clock);
    start = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if (cdf_done) begin
        done_edge = edge_cnt;
        break;
      end
    end
    check({name, "_done_edge"}, done_edge, 2818);
    check({name, "_writes"}, wr_cnt, 256);
    check({name, "_queue_left"}, exp_q.size(), 0);
    check({name, "_addr_form"}, addr_bad, 0);
    exp_q.delete();
    @(negedge clock);
    check({name, "_done_hold"}, cdf_done, 1);
    check({name, "_we_in_done"}, lutWE, 0);
    start = 1'b0;
    @(posedge clock);
    #1;
    check({name, "_done_clear"}, cdf_done, 0);
    check({name, "_addr_idle"}, m2ReadAddr, {inputBaseOffset, 15'b0});
  endtask

  task automatic load_uniform(input int bank);
    fill_bank(bank, {16'hAAAA, 20'd1200});
    for (int v = 0; v < 256; v++) exp_lut[v] = v;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    inputBaseOffset = 1'b0;
    fill_bank(0, 36'd0);
    fill_bank(1, 36'd0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);

    check("rst_lutWE", lutWE, 0);
    check("rst_lutWriteAddr", lutWriteAddr, 0);
    check("rst_lutWriteData", lutWriteData, 0);
    check("rst_cdf_done", cdf_done, 0);
    check("rst_m2ReadAddr", m2ReadAddr, 16'h0000);
    inputBaseOffset = 1'b1;
    #1;
    check("rst_m2ReadAddr_bank1", m2ReadAddr, 16'h8000);
    inputBaseOffset = 1'b0;

    // Uniform image: 1200 per bin gives the identity LUT.
    load_uniform(0);
    push_lut(256);
    run_full("uniform");

    // Single-valued image: den = 0, every entry is 0.
    fill_bank(0, {16'hAAAA, 20'd0});
    mem[0][100] = {16'hAAAA, 20'd307200};
    for (int v = 0; v < 256; v++) exp_lut[v] = 0;
    push_lut(256);
    run_full("single");

    // Two-valued image.
    fill_bank(0, {16'hAAAA, 20'd0});
    mem[0][10]  = {16'hAAAA, 20'd153600};
    mem[0][200] = {16'hAAAA, 20'd153600};
    for (int v = 0; v < 256; v++) exp_lut[v] = (v < 200) ? 0 : 255;
    push_lut(256);
    run_full("two_valued");

    // Untagged low half with garbage counts.
    for (int b = 0; b < 128; b++) mem[0][b] = {16'h0000, 20'(b * 4099 + 17)};
    for (int b = 128; b < 256; b++) mem[0][b] = {16'hAAAA, 20'd2400};
    for (int v = 0; v < 256; v++) exp_lut[v] = (v <= 128) ? 0 : ((v - 128) * 255) / 127;
    check("untagged_lut255_model", exp_lut[255], 255);
    push_lut(256);
    run_full("untagged");

    // Start dropped during bin 50's evaluation, then a full rebuild.
    load_uniform(0);
    push_lut(50);
    wr_cnt = 0;
    @(negedge clock);
    start = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (edge_cnt == 762) break;
    end
    check("drop_reached_edge", edge_cnt, 762);
    start = 1'b0;
    @(posedge clock);
    #1;
    check("drop_lutWE", lutWE, 0);
    check("drop_lutWriteAddr", lutWriteAddr, 0);
    check("drop_lutWriteData", lutWriteData, 0);
    check("drop_cdf_done", cdf_done, 0);
    check("drop_m2ReadAddr", m2ReadAddr, 16'h0000);
    check("drop_partial_writes", wr_cnt, 50);
    check("drop_queue_left", exp_q.size(), 0);
    exp_q.delete();
    push_lut(256);
    run_full("restart");

    // Bank select: real data in bank 1, a different image in bank 0.
    load_uniform(1);
    fill_bank(0, {16'hAAAA, 20'd0});
    mem[0][100] = {16'hAAAA, 20'd307200};
    inputBaseOffset = 1'b1;
    push_lut(256);
    run_full("bank1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdf_lut_builder.md
# cdf_lut_builder

Second stage of the histogram equalizer, directly downstream of the input pipeline. Once the input pipeline signals `input_done`, this block reads the 256 tagged pixel-count bins it left in scratchpad m2. It builds the cumulative distribution and writes an 8-bit equalization LUT, `lut[v] = floor((cdf[v] - cdf_min) * 255 / (total - cdf_min))`, for the remap stage to consume.

## Interface
- `BINS`, 256, number of histogram bins (pixel values 0..255)
- `TAG`, 16'hAAAA, valid-entry marker in m2 bits [35:20]
- `CNT_W`, 20, count field width, m2 bits [19:0]
- `ADDR_W`, 16, scratchpad address width
- `clock`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  level; driven from `input_done`; must stay high for the whole run
- `inputBaseOffset`  in  1  m2 bank select, placed in address bit 15
- `m2ReadAddr`  out  16  `{inputBaseOffset, 7'b0, bin[7:0]}`
- `m2ReadBus`  in  36  combinational-read data for `m2ReadAddr`
- `lutWE`  out  1  LUT write strobe, one cycle per bin
- `lutWriteAddr`  out  8  bin index
- `lutWriteData`  out  8  equalized value
- `cdf_done`  out  1  LUT complete; held high while `start` is high

## Operation
- Bin decode: `count = (m2ReadBus[35:20] == TAG) ? m2ReadBus[19:0] : 0`. Untagged entries are empty bins.
- States: IDLE, SCAN, EVAL_RD, EVAL_DIV, EVAL_WR, DONE.
- IDLE: all registers cleared. `start` high moves to SCAN with `bin = 0`.
- SCAN, one bin per cycle over bins 0..255:
  - `total += count`.
  - `cdf_min` latches the count of the first nonzero bin.
  - After bin 255, go to EVAL_RD with `bin = 0` and `cdf = 0`.
- EVAL_RD (1 cycle):
  - Re-read the bin; `cdf += count`.
  - `num = (cdf_new >= cdf_min) ? (cdf_new - cdf_min) * 255 : 0` (27 bits).
  - `den = total - cdf_min` (20 bits).
  - Load the divider; go to EVAL_DIV.
- EVAL_DIV (8 cycles): restoring division, one quotient bit per cycle, MSB first. Go to EVAL_WR.
- EVAL_WR (1 cycle):
  - `lutWE = 1`, `lutWriteAddr = bin`, `lutWriteData = quotient`.
  - If `bin == 255`, go to DONE; otherwise `bin++` and return to EVAL_RD.
- `den == 0` (empty or single-valued image): quotient is forced to 0 without dividing, but state timing is unchanged.
- Quotient is floor and always ≤ 255, since `num/255 ≤ den`. No saturation logic is needed.
- DONE: `cdf_done = 1`, `lutWE = 0`. The block stays in DONE until `start` drops.
- `start` low in any state: next edge returns to IDLE and all outputs go to their reset values. Any partial LUT is abandoned; the next start rebuilds it completely.

## Timing
- Reset values: `m2ReadAddr = {inputBaseOffset, 15'b0}`; `lutWE`, `lutWriteAddr`, `lutWriteData` and `cdf_done` are all 0.
- m2 reads are combinational, with data used in the same cycle. `lutWE`, `lutWriteAddr`, `lutWriteData` and `cdf_done` are registered.
- Per-bin EVAL cost is 10 cycles: RD 1 + DIV 8 + WR 1.
- Latency, counted in rising edges with `start` high: IDLE→SCAN 1, SCAN 256, EVAL 2560. `cdf_done` is first high after edge 2818.
- The LUT write for bin b is high during cycle `257 + 10b + 10`. Writes are strictly ascending by address, each exactly once.
- Widths:
  - `total` and `cdf` are 20 bits; the maximum is 307200 < 2^19, so neither can overflow.
  - Divider remainder is 27 bits; shifted divisor is `den << i`, i = 7..0.

## Structure
- `hist_eq_pkg` holds:
  - `TAG`, `BINS`, `CNT_W`, `ADDR_W`;
  - the TOTAL_PIXELS constant (307200);
  - the state enum `cdf_state_t`, shared with later stages.
- Sub-module `lut_divider`:
  - inputs: `load`, `num[26:0]`, `den[19:0]`;
  - outputs: `q[7:0]`, and `busy`, which is high for 8 cycles;
  - same clock and reset as the parent.
- FSM, counters, accumulators and m2 addressing live in `cdf_lut_builder`.

## Test plan
- **Uniform image:** all 256 bins tagged, count 1200 each → `lut[v] = v` for every v; `cdf_done` after edge 2818.
- **Single-valued image:** bin 100 = 307200, all others 0 → `den = 0`, all 256 writes carry 0, timing unchanged.
- **Two-valued image:** bins 10 and 200 at 153600 each → `lut[0..199] = 0`, `lut[200..255] = 255`.
- **Untagged bins:**
  - bins 0..127 have tag 16'h0000 with garbage counts; bins 128..255 are tagged with count 2400;
  - expect `lut[0..128] = 0`, `lut[v] = floor((v-128)*255/127)` for v > 128, and `lut[255] = 255`.
- **Start drop mid-run:** drop `start` during the EVAL of bin 50 → all outputs at reset values after the next edge; re-asserting `start` yields a complete, correct LUT of 256 ascending writes.
- **Bank select:** `inputBaseOffset = 1` → every `m2ReadAddr` has bit 15 set and bits [14:8] zero across both passes.
